// File: rtl/jpeg_bit_unpacker.sv
// JPEG entropy-stream bit unpacker: removes 0xFF00 stuffing, detects markers and
// presents a left-aligned 16-bit window of the oldest unconsumed stream bits.
module jpeg_bit_unpacker #(
   parameter int BUF_BITS = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [15:0] bit_window,
   output logic [6:0]  bits_avail,
   input  logic        consume_en,
   input  logic [4:0]  consume_len,
   input  logic        align_req,
   output logic        marker_detected,
   output logic [7:0]  marker_code,
   input  logic        marker_clear,
   output logic        underflow_err,
   output logic [1:0]  fsm_state
);

   // Handshake: a byte moves when byte_valid && byte_ready are high in the same
   // cycle; byte_ready depends only on registered state, never on consume inputs.

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      GOT_FF = 2'd1,
      MARKER = 2'd2
   } state_t;

   state_t              state, state_next;
   logic [BUF_BITS-1:0] buf_q, buf_shifted, buf_next;
   logic [6:0]          fill_q, fill_shifted, fill_next;
   logic [6:0]          len_ext, align_len, ins_shift;
   logic                accept, append_en, load_marker, underflow_set;
   logic [7:0]          append_byte;
   logic                marker_q, underflow_q;
   logic [7:0]          code_q;
   logic [15:0]         window_mask;

   assign byte_ready = !reset && (state != MARKER) && (fill_q <= 7'(BUF_BITS - 8));
   assign accept     = byte_valid && byte_ready;

   always_ff @(posedge clock) begin
      if (reset) state <= NORMAL;
      else       state <= state_next;
   end

   always_comb begin
      state_next  = state;
      append_en   = 1'b0;
      append_byte = byte_in;
      load_marker = 1'b0;
      case (state)
         NORMAL: begin
            if (accept) begin
               if (byte_in == 8'hFF) state_next = GOT_FF;
               else                  append_en  = 1'b1;
            end
         end
         GOT_FF: begin
            if (accept) begin
               if (byte_in == 8'h00) begin
                  append_en   = 1'b1;
                  append_byte = 8'hFF;
                  state_next  = NORMAL;
               end else if (byte_in != 8'hFF) begin
                  load_marker = 1'b1;
                  state_next  = MARKER;
               end
            end
         end
         MARKER: begin
            if (marker_clear) state_next = NORMAL;
         end
         default: state_next = NORMAL;
      endcase
   end

   // Consume (or align) is applied first; an appended byte lands right after
   // the surviving bits.
   always_comb begin
      len_ext       = {2'b00, consume_len};
      align_len     = {4'b0000, fill_q[2:0]};
      buf_shifted   = buf_q;
      fill_shifted  = fill_q;
      underflow_set = 1'b0;
      if (consume_en) begin
         if (len_ext <= fill_q) begin
            buf_shifted  = buf_q << len_ext;
            fill_shifted = fill_q - len_ext;
         end else begin
            underflow_set = 1'b1;
         end
      end else if (align_req) begin
         buf_shifted  = buf_q << align_len;
         fill_shifted = fill_q - align_len;
      end
      ins_shift = 7'(BUF_BITS - 8) - fill_shifted;
      buf_next  = buf_shifted;
      fill_next = fill_shifted;
      if (append_en) begin
         buf_next  = (buf_shifted & ~({{(BUF_BITS-8){1'b0}}, 8'hFF} << ins_shift))
                   | ({{(BUF_BITS-8){1'b0}}, append_byte} << ins_shift);
         fill_next = fill_shifted + 7'd8;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         buf_q       <= '0;
         fill_q      <= '0;
         marker_q    <= 1'b0;
         code_q      <= 8'h00;
         underflow_q <= 1'b0;
      end else begin
         buf_q    <= buf_next;
         fill_q   <= fill_next;
         marker_q <= (state_next == MARKER);
         if (load_marker)   code_q      <= byte_in;
         if (underflow_set) underflow_q <= 1'b1;
      end
   end

   assign window_mask     = (fill_q >= 7'd16) ? 16'hFFFF : ~(16'hFFFF >> fill_q);
   assign bit_window      = reset ? 16'h0000 : (buf_q[BUF_BITS-1 -: 16] & window_mask);
   assign bits_avail      = fill_q;
   assign marker_detected = marker_q;
   assign marker_code     = code_q;
   assign underflow_err   = underflow_q;
   assign fsm_state       = state;

endmodule

// File: tb/tb_jpeg_bit_unpacker.sv
// Directed bench for jpeg_bit_unpacker: hand-computed windows, fills and flags
// for stuffing, markers, consume/append overlap, underflow, align and reset.
module tb_jpeg_bit_unpacker;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic [15:0] bit_window;
   logic [6:0]  bits_avail;
   logic        consume_en = 1'b0;
   logic [4:0]  consume_len = 5'd0;
   logic        align_req = 1'b0;
   logic        marker_detected;
   logic [7:0]  marker_code;
   logic        marker_clear = 1'b0;
   logic        underflow_err;
   logic [1:0]  fsm_state;

   int n_checks = 0;
   int n_fail   = 0;

   jpeg_bit_unpacker #(.BUF_BITS(32)) dut (
      .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .bit_window(bit_window), .bits_avail(bits_avail),
      .consume_en(consume_en), .consume_len(consume_len), .align_req(align_req),
      .marker_detected(marker_detected), .marker_code(marker_code),
      .marker_clear(marker_clear), .underflow_err(underflow_err), .fsm_state(fsm_state)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock with the currently driven inputs, then drop all strobes.
   task automatic cycle();
      @(posedge clock); #1;
      byte_valid   = 1'b0;
      consume_en   = 1'b0;
      consume_len  = 5'd0;
      align_req    = 1'b0;
      marker_clear = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      byte_in = b; byte_valid = 1'b1;
      cycle();
   endtask

   task automatic consume(input logic [4:0] n);
      consume_en = 1'b1; consume_len = n;
      cycle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      push(8'hA5);
      reset = 1'b1; byte_in = 8'h12; byte_valid = 1'b1;
      @(posedge clock); #1;
      n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", byte_ready); end
      n_checks++; if (bit_window !== 16'h0000) begin n_fail++; $display("FAIL reset_window: got %h want 0000", bit_window); end
      n_checks++; if (bits_avail !== 7'd0) begin n_fail++; $display("FAIL reset_avail: got %0d want 0", bits_avail); end
      n_checks++; if (marker_detected !== 1'b0 || marker_code !== 8'h00 || underflow_err !== 1'b0)
         begin n_fail++; $display("FAIL reset_flags: got %b/%h/%b want 0/00/0", marker_detected, marker_code, underflow_err); end
      n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
      byte_valid = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      push(8'hA5);
      push(8'h3C);
      n_checks++; if (bits_avail !== 7'd16) begin n_fail++; $display("FAIL basic_avail: got %0d want 16", bits_avail); end
      n_checks++; if (bit_window !== 16'hA53C) begin n_fail++; $display("FAIL basic_window: got %h want a53c", bit_window); end
   endtask

   task automatic test_stuffing();
      do_reset();
      push(8'hFF);
      n_checks++; if (bits_avail !== 7'd0 || fsm_state !== 2'd1) begin n_fail++; $display("FAIL stuff_pending: got avail %0d state %0d want 0/1", bits_avail, fsm_state); end
      push(8'h00);
      push(8'h12);
      n_checks++; if (bits_avail !== 7'd16) begin n_fail++; $display("FAIL stuff_avail: got %0d want 16", bits_avail); end
      n_checks++; if (bit_window !== 16'hFF12) begin n_fail++; $display("FAIL stuff_window: got %h want ff12", bit_window); end
      n_checks++; if (marker_detected !== 1'b0) begin n_fail++; $display("FAIL stuff_marker: got %b want 0", marker_detected); end
   endtask

   task automatic test_marker();
      do_reset();
      push(8'h80); push(8'hFF); push(8'hFF); push(8'hD9);
      n_checks++; if (bits_avail !== 7'd8) begin n_fail++; $display("FAIL marker_avail: got %0d want 8", bits_avail); end
      n_checks++; if (marker_detected !== 1'b1 || marker_code !== 8'hD9) begin n_fail++; $display("FAIL marker_flag: got %b/%h want 1/d9", marker_detected, marker_code); end
      n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL marker_ready: got %b want 0", byte_ready); end
      n_checks++; if (bit_window !== 16'h8000) begin n_fail++; $display("FAIL marker_window: got %h want 8000", bit_window); end
      // bytes offered while stalled are not taken; consume still works
      byte_in = 8'h33; byte_valid = 1'b1;
      cycle();
      consume(5'd1);
      n_checks++; if (bits_avail !== 7'd7 || bit_window !== 16'h0000) begin n_fail++; $display("FAIL marker_consume: got %0d/%h want 7/0000", bits_avail, bit_window); end
      marker_clear = 1'b1;
      cycle();
      n_checks++; if (marker_detected !== 1'b0 || marker_code !== 8'hD9 || byte_ready !== 1'b1)
         begin n_fail++; $display("FAIL marker_clear: got det %b code %h ready %b want 0/d9/1", marker_detected, marker_code, byte_ready); end
      push(8'h11);
      n_checks++; if (bits_avail !== 7'd15 || bit_window !== 16'h0022) begin n_fail++; $display("FAIL marker_resume: got %0d/%h want 15/0022", bits_avail, bit_window); end
   endtask

   task automatic test_consume_append();
      do_reset();
      push(8'hA5); push(8'h3C);
      byte_in = 8'h7E; byte_valid = 1'b1; consume_en = 1'b1; consume_len = 5'd3;
      cycle();
      n_checks++; if (bits_avail !== 7'd21) begin n_fail++; $display("FAIL overlap_avail: got %0d want 21", bits_avail); end
      n_checks++; if (bit_window !== 16'h29E3) begin n_fail++; $display("FAIL overlap_window: got %h want 29e3", bit_window); end
      consume(5'd0);
      n_checks++; if (bits_avail !== 7'd21 || bit_window !== 16'h29E3) begin n_fail++; $display("FAIL consume_zero: got %0d/%h want 21/29e3", bits_avail, bit_window); end
      consume(5'd16);
      n_checks++; if (bits_avail !== 7'd5 || bit_window !== 16'hF000) begin n_fail++; $display("FAIL consume_16: got %0d/%h want 5/f000", bits_avail, bit_window); end
   endtask

   task automatic test_underflow_align();
      do_reset();
      push(8'hA5);
      consume(5'd3);
      n_checks++; if (bits_avail !== 7'd5 || bit_window !== 16'h2800) begin n_fail++; $display("FAIL uf_setup: got %0d/%h want 5/2800", bits_avail, bit_window); end
      consume(5'd6);
      n_checks++; if (bits_avail !== 7'd5 || bit_window !== 16'h2800) begin n_fail++; $display("FAIL uf_unchanged: got %0d/%h want 5/2800", bits_avail, bit_window); end
      n_checks++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL uf_flag: got %b want 1", underflow_err); end
      push(8'hC3);
      n_checks++; if (bits_avail !== 7'd13 || bit_window !== 16'h2E18) begin n_fail++; $display("FAIL uf_append: got %0d/%h want 13/2e18", bits_avail, bit_window); end
      n_checks++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b want 1", underflow_err); end
      align_req = 1'b1;
      cycle();
      n_checks++; if (bits_avail !== 7'd8 || bit_window !== 16'hC300) begin n_fail++; $display("FAIL align: got %0d/%h want 8/c300", bits_avail, bit_window); end
      align_req = 1'b1; consume_en = 1'b1; consume_len = 5'd4;
      cycle();
      n_checks++; if (bits_avail !== 7'd4 || bit_window !== 16'h3000) begin n_fail++; $display("FAIL align_vs_consume: got %0d/%h want 4/3000", bits_avail, bit_window); end
      align_req = 1'b1;
      cycle();
      n_checks++; if (bits_avail !== 7'd0 || bit_window !== 16'h0000) begin n_fail++; $display("FAIL align_partial: got %0d/%h want 0/0000", bits_avail, bit_window); end
   endtask

   task automatic test_full_and_reset();
      do_reset();
      n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL uf_reset_clear: got %b want 0", underflow_err); end
      push(8'h11); push(8'h22); push(8'h33);
      n_checks++; if (bits_avail !== 7'd24 || byte_ready !== 1'b1) begin n_fail++; $display("FAIL fill24: got %0d/%b want 24/1", bits_avail, byte_ready); end
      push(8'h44);
      n_checks++; if (bits_avail !== 7'd32 || byte_ready !== 1'b0) begin n_fail++; $display("FAIL full: got %0d/%b want 32/0", bits_avail, byte_ready); end
      n_checks++; if (bit_window !== 16'h1122) begin n_fail++; $display("FAIL full_window: got %h want 1122", bit_window); end
      consume(5'd8);
      n_checks++; if (bits_avail !== 7'd24 || byte_ready !== 1'b1 || bit_window !== 16'h2233)
         begin n_fail++; $display("FAIL unfull: got %0d/%b/%h want 24/1/2233", bits_avail, byte_ready, bit_window); end
      do_reset();
      push(8'hFF);
      n_checks++; if (fsm_state !== 2'd1) begin n_fail++; $display("FAIL got_ff_state: got %0d want 1", fsm_state); end
      do_reset();
      push(8'h00);
      n_checks++; if (bits_avail !== 7'd8 || bit_window !== 16'h0000) begin n_fail++; $display("FAIL reset_pending_ff: got %0d/%h want 8/0000", bits_avail, bit_window); end
      push(8'h55);
      n_checks++; if (bits_avail !== 7'd16 || bit_window !== 16'h0055) begin n_fail++; $display("FAIL after_reset_append: got %0d/%h want 16/0055", bits_avail, bit_window); end
   endtask

   initial begin
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      test_reset();
      test_basic();
      test_stuffing();
      test_marker();
      test_consume_append();
      test_underflow_align();
      test_full_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
